// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

   localparam logic [7:0] ADDR_DATA_DEFAULT = 8'hFE;
   localparam logic [7:0] ADDR_STAT_DEFAULT = 8'hFD;

   // Bit positions inside the status byte
   localparam int unsigned VALID = 0;
   localparam int unsigned OVR   = 1;
   localparam int unsigned FERR  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/mmio_uart_rx.sv
// 8N1 UART receiver with a two-address load interface (data byte and status byte).
module mmio_uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  ADDR_DATA    = ADDR_DATA_DEFAULT,
   parameter logic [7:0]  ADDR_STAT    = ADDR_STAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [7:0] Address,
   input  logic       RdEn,
   output logic [7:0] DataOut,
   output logic       Hit,
   output logic       RxValid
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic rxs;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   uart_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             commit;
   logic             ferr_set;

   logic [7:0] rx_data_q;
   logic       valid_q, ovr_q, ferr_q;
   logic       rd_data, rd_stat;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      commit   = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               // A start bit that is high again at its midpoint was a glitch
               state_d = rxs ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d          = '0;
               shift_d[bit_q] = rxs;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rxs) begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rd_data = RdEn && (Address == ADDR_DATA);
   assign rd_stat = RdEn && (Address == ADDR_STAT);

   // A data read in the same cycle as a commit frees the holding register, so no overrun
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         if (commit && valid_q && !rd_data) begin
            ovr_q <= 1'b1;
         end else if (commit) begin
            rx_data_q <= shift_q;
            valid_q   <= 1'b1;
            ovr_q     <= 1'b0;
         end else if (rd_data) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end

         if (ferr_set)     ferr_q <= 1'b1;
         else if (rd_stat) ferr_q <= 1'b0;
      end
   end

   always_comb begin
      DataOut = '0;
      Hit     = 1'b0;
      if (Address == ADDR_DATA) begin
         DataOut = rx_data_q;
         Hit     = 1'b1;
      end else if (Address == ADDR_STAT) begin
         DataOut[VALID] = valid_q;
         DataOut[OVR]   = ovr_q;
         DataOut[FERR]  = ferr_q;
         Hit            = 1'b1;
      end
   end

   assign RxValid = valid_q;

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Randomised bench for mmio_uart_rx against a frame-level model of the receive buffer and flags.
module tb_mmio_uart_rx;

   localparam int unsigned CPB    = 16;
   localparam logic [7:0]  A_DATA = 8'hFE;
   localparam logic [7:0]  A_STAT = 8'hFD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] Address = 8'h00;
   logic       RdEn = 1'b0;
   logic [7:0] DataOut;
   logic       Hit;
   logic       RxValid;

   mmio_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .ADDR_DATA    (A_DATA),
      .ADDR_STAT    (A_STAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .Address (Address),
      .RdEn    (RdEn),
      .DataOut (DataOut),
      .Hit     (Hit),
      .RxValid (RxValid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: state of the receive buffer as seen by software
   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ovr   = 1'b0;
   logic       m_ferr  = 1'b0;

   function automatic logic [7:0] exp_read(input logic [7:0] a);
      if (a == A_DATA) return m_data;
      if (a == A_STAT) return {5'b0, m_ferr, m_ovr, m_valid};
      return 8'h00;
   endfunction

   task automatic model_clear();
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok)     m_ferr = 1'b1;
      else if (m_valid) m_ovr  = 1'b1;
      else begin
         m_data  = b;
         m_valid = 1'b1;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 8N1 frame; rd_at > 0 issues a data-read pulse active at that posedge count
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at);
      rx = 1'b0;
      for (int c = 1; c <= 10 * int'(CPB); c++) begin
         if (c == rd_at) begin
            Address = A_DATA;
            RdEn    = 1'b1;
         end
         @(posedge clk);
         #1;
         RdEn = 1'b0;
         if (c % int'(CPB) == 0) begin
            int k;
            k = c / int'(CPB);
            if (k <= 8)      rx = b[k-1];
            else if (k == 9) rx = stop_bit;
            else             rx = stop_bit ? 1'b1 : 1'b0;
         end
      end
   endtask

   task automatic sample(input logic [7:0] a, output logic [7:0] d, output logic h);
      Address = a;
      RdEn    = 1'b0;
      @(negedge clk);
      d = DataOut;
      h = Hit;
      @(posedge clk);
      #1;
   endtask

   task automatic read_pulse(input logic [7:0] a);
      Address = a;
      RdEn    = 1'b1;
      tick(1);
      RdEn = 1'b0;
      if (a == A_DATA) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      if (a == A_STAT) m_ferr = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      logic       h;
      rst = 1'b0;
      rx  = 1'b1;
      tick(3);
      model_clear();
      sample(A_STAT, d, h);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_stat_in_rst got=%h exp=%h", d, 8'h00); end
      total++; if (RxValid !== 1'b0) begin bad++; $display("FAIL reset_rxvalid got=%b exp=0", RxValid); end
      rst = 1'b1;
      tick(2);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL reset_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      total++; if (h !== 1'b1) begin bad++; $display("FAIL reset_hit_stat got=%b exp=1", h); end
      sample(A_DATA, d, h);
      total++; if (d !== 8'h00 || h !== 1'b1) begin bad++; $display("FAIL reset_data got=%h/%b exp=00/1", d, h); end
      sample(8'h10, d, h);
      total++; if (h !== 1'b0 || d !== 8'h00) begin bad++; $display("FAIL miss_addr got=%h/%b exp=00/0", d, h); end
   endtask

   task automatic test_single();
      logic [7:0] d;
      logic       h;
      logic [7:0] b;
      b  = 8'hA5;
      rx = 1'b0;
      for (int c = 1; c <= 10 * int'(CPB); c++) begin
         @(posedge clk);
         #1;
         if (c == 150) begin
            total++; if (RxValid !== 1'b0) begin bad++; $display("FAIL rxvalid_early got=%b exp=0", RxValid); end
         end
         if (c == 158) begin
            total++; if (RxValid !== 1'b1) begin bad++; $display("FAIL rxvalid_rise got=%b exp=1", RxValid); end
         end
         if (c % int'(CPB) == 0) begin
            int k;
            k  = c / int'(CPB);
            rx = (k <= 8) ? b[k-1] : 1'b1;
         end
      end
      model_frame(b, 1'b1);
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL single_data got=%h exp=%h", d, exp_read(A_DATA)); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL single_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      read_pulse(A_DATA);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL single_clear got=%h exp=%h", d, exp_read(A_STAT)); end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      logic       h;
      send_frame(8'h3C, 1'b1, 0);
      model_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1, 0);
      model_frame(8'hC3, 1'b1);
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL ovr_data got=%h exp=%h", d, exp_read(A_DATA)); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL ovr_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      read_pulse(A_DATA);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL ovr_clear got=%h exp=%h", d, exp_read(A_STAT)); end
   endtask

   task automatic test_framing();
      logic [7:0] d;
      logic       h;
      send_frame(8'($urandom), 1'b0, 0);
      model_frame(8'h00, 1'b0);
      tick(3 * CPB);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL ferr_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      total++; if (RxValid !== m_valid) begin bad++; $display("FAIL ferr_rxvalid got=%b exp=%b", RxValid, m_valid); end
      rx = 1'b1;
      tick(CPB);
      send_frame(8'h7E, 1'b1, 0);
      model_frame(8'h7E, 1'b1);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL ferr_then_byte got=%h exp=%h", d, exp_read(A_STAT)); end
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL ferr_byte_data got=%h exp=%h", d, exp_read(A_DATA)); end
      read_pulse(A_STAT);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL ferr_clear got=%h exp=%h", d, exp_read(A_STAT)); end
      read_pulse(A_DATA);
   endtask

   task automatic test_glitch();
      logic [7:0] d;
      logic       h;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(3 * CPB);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL glitch_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      send_frame(8'h81, 1'b1, 0);
      model_frame(8'h81, 1'b1);
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL glitch_next_data got=%h exp=%h", d, exp_read(A_DATA)); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL glitch_next_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      read_pulse(A_DATA);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      logic       h;
      logic [7:0] b;
      send_frame(8'($urandom), 1'b1, 0);
      total++; if (RxValid !== 1'b1) begin bad++; $display("FAIL prerst_valid got=%b exp=1", RxValid); end
      // bits 3..7 and stop are high so the line is idle once the receiver restarts
      b  = 8'hF8 | 8'($urandom_range(0, 7));
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = b[3];
      tick(5);
      rst = 1'b0;
      tick(2);
      model_clear();
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL midrst_data got=%h exp=%h", d, exp_read(A_DATA)); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL midrst_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      total++; if (RxValid !== 1'b0) begin bad++; $display("FAIL midrst_rxvalid got=%b exp=0", RxValid); end
      rst = 1'b1;
      rx  = 1'b1;
      tick(6 * CPB);
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL postrst_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      send_frame(8'h55, 1'b1, 0);
      model_frame(8'h55, 1'b1);
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL postrst_data got=%h exp=%h", d, exp_read(A_DATA)); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL postrst_stat2 got=%h exp=%h", d, exp_read(A_STAT)); end
      read_pulse(A_DATA);
   endtask

   task automatic test_read_on_commit();
      logic [7:0] d;
      logic       h;
      logic [7:0] b1, b2;
      b1 = 8'($urandom);
      b2 = ~b1;
      send_frame(b1, 1'b1, 0);
      model_frame(b1, 1'b1);
      // commit lands at posedge 155: 2 sync flops + IDLE detect + half bit + 8 bits + stop midpoint
      send_frame(b2, 1'b1, 155);
      m_data  = b2;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
      total++; if (RxValid !== 1'b1) begin bad++; $display("FAIL rdcommit_rxvalid got=%b exp=1", RxValid); end
      sample(A_STAT, d, h);
      total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL rdcommit_stat got=%h exp=%h", d, exp_read(A_STAT)); end
      sample(A_DATA, d, h);
      total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL rdcommit_data got=%h exp=%h", d, exp_read(A_DATA)); end
      read_pulse(A_DATA);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       h;
      logic [7:0] b;
      logic       ok;
      int         act;
      for (int n = 0; n < 10; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok, 0);
         if (!ok) begin
            tick(2 * CPB);
            rx = 1'b1;
            tick(CPB);
         end
         model_frame(b, ok);
         sample(A_DATA, d, h);
         total++; if (d !== exp_read(A_DATA)) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", n, d, exp_read(A_DATA)); end
         sample(A_STAT, d, h);
         total++; if (d !== exp_read(A_STAT)) begin bad++; $display("FAIL rand%0d_stat got=%h exp=%h", n, d, exp_read(A_STAT)); end
         total++; if (RxValid !== m_valid) begin bad++; $display("FAIL rand%0d_rxvalid got=%b exp=%b", n, RxValid, m_valid); end
         act = int'($urandom_range(0, 3));
         if (act == 1) read_pulse(A_DATA);
         if (act == 2) read_pulse(A_STAT);
         if (act == 3) read_pulse(8'($urandom_range(0, 8'hFC)));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_framing();
      test_glitch();
      test_reset_midframe();
      test_read_on_commit();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
